// File: rtl/sisc_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : sisc_fetch_if
//  Brief    : Core-side and instruction-memory-side signals of the fetch stage.
//  Revision : 1.0 - initial release
// ============================================================================
interface sisc_fetch_if #(
  parameter int ADDR_W = 16
) ();

  // core side
  logic              stall;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic [31:0]       instruction;
  logic              instr_valid;
  logic [ADDR_W-1:0] instr_pc;

  // instruction memory side
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (
    input  stall,
    input  br_taken,
    input  br_target,
    input  imem_ack,
    input  imem_rdata,
    output imem_req,
    output imem_addr,
    output instruction,
    output instr_valid,
    output instr_pc
  );

  modport slave (
    output stall,
    output br_taken,
    output br_target,
    output imem_ack,
    output imem_rdata,
    input  imem_req,
    input  imem_addr,
    input  instruction,
    input  instr_valid,
    input  instr_pc
  );

endinterface
`default_nettype wire

// File: rtl/sisc_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : sisc_fetch
//  Brief    : SISC instruction fetch stage: PC, imem req/ack, instruction reg.
//  Revision : 1.0 - initial release
// ============================================================================
module sisc_fetch #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_f,
  sisc_fetch_if.master bus
);

  localparam int              c_STATE_W = 2;
  localparam logic [ADDR_W-1:0] c_PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [c_STATE_W-1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_flush_addr;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_valid;

  logic [ADDR_W-1:0] w_pc_inc;

  assign w_pc_inc = r_pc + c_PC_ONE;

  always_ff @(posedge clk) begin
    if (rst_f) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_flush_addr <= '0;
      r_instr      <= '0;
      r_instr_pc   <= '0;
      r_valid      <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (bus.br_taken) begin
            r_pc <= bus.br_target;
            // Without an ack the old read is still in flight and must drain.
            if (!bus.imem_ack) begin
              r_flush_addr <= r_pc;
              r_state      <= FLUSH;
            end
          end else if (bus.imem_ack) begin
            r_instr    <= bus.imem_rdata;
            r_instr_pc <= r_pc;
            r_pc       <= w_pc_inc;
            r_valid    <= 1'b1;
            r_state    <= ISSUE;
          end
        end

        ISSUE: begin
          if (bus.br_taken) begin
            r_pc    <= bus.br_target;
            r_valid <= 1'b0;
            r_state <= FETCH;
          end else if (!bus.stall) begin
            r_valid <= 1'b0;
            r_state <= FETCH;
          end
        end

        FLUSH: begin
          if (bus.br_taken) begin
            r_pc <= bus.br_target;
          end
          if (bus.imem_ack) begin
            r_state <= FETCH;
          end
        end

        default: begin
          r_valid <= 1'b0;
          r_state <= FETCH;
        end
      endcase
    end
  end

  // Request is a function of state only, masked while reset is held.
  assign bus.imem_req    = (r_state != ISSUE) && !rst_f;
  assign bus.imem_addr   = (r_state == FLUSH) ? r_flush_addr : r_pc;
  assign bus.instruction = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_valid;

endmodule
`default_nettype wire
